// File: rtl/aes_skew_perm.sv
// Skewed ShiftRows/InvShiftRows: row r leaves r cycles after entry, one word per cycle, no back-pressure.
// Defining AES_SKEW_REG_OUT_EN adds an output register stage (+1 cycle on all paths).
module aes_skew_perm #(
    parameter int NCOL = 4,
    parameter int DW   = 8
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   CE,
    input  logic                   DIN_VALID,
    input  logic                   DEC,
    input  logic [4*DW*NCOL-1:0]   DIN,
    output logic [4*DW*NCOL-1:0]   DOUT,
    output logic                   DOUT_VALID
);
    localparam int W = 4 * DW * NCOL;

    function automatic int shift_of(input int r);
        if (NCOL == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    function automatic int msb_of(input int r, input int c);
        return (NCOL - c) * 4 * DW - r * DW - 1;
    endfunction

    logic [W-1:0] perm;
    logic [1:0]   fill;
    logic         last_dec;
    logic         perm_valid;

    for (genvar c = 0; c < NCOL; c++) begin : g_row0
        localparam int M = msb_of(0, c);
        assign perm[M -: DW] = DIN[M -: DW];
    end

    // The direction mux sits in front of the delay line, so each entry carries its own DEC.
    for (genvar r = 1; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NCOL; c++) begin : g_col
            localparam int ENC_SRC = (c + shift_of(r)) % NCOL;
            localparam int DEC_SRC = (c + NCOL - shift_of(r)) % NCOL;
            localparam int M_OUT   = msb_of(r, c);
            localparam int M_ENC   = msb_of(r, ENC_SRC);
            localparam int M_DEC   = msb_of(r, DEC_SRC);

            logic [DW-1:0] dly [r];
            logic [DW-1:0] src;

            assign src = DEC ? DIN[M_DEC -: DW] : DIN[M_ENC -: DW];

            always_ff @(posedge CLK) begin
                if (!RSTN) begin
                    for (int k = 0; k < r; k++) dly[k] <= '0;
                end else if (CE) begin
                    dly[0] <= src;
                    for (int k = 1; k < r; k++) dly[k] <= dly[k-1];
                end
            end

            assign perm[M_OUT -: DW] = dly[r-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            fill     <= 2'd0;
            last_dec <= 1'b0;
        end else if (CE) begin
            if (!DIN_VALID) begin
                fill <= 2'd0;
            end else if (DEC != last_dec) begin
                fill     <= 2'd1;
                last_dec <= DEC;
            end else if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    assign perm_valid = CE & DIN_VALID & (DEC == last_dec) & (fill == 2'd3);

`ifdef AES_SKEW_REG_OUT_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
        end else if (CE) begin
            DOUT       <= perm;
            DOUT_VALID <= perm_valid;
        end
    end
`else
    assign DOUT       = perm;
    assign DOUT_VALID = perm_valid;
`endif

endmodule

// File: tb/tb_aes_skew_perm.sv
// Directed bench for aes_skew_perm: NCOL=4 main instance plus an NCOL=8 instance on a fixed pattern.
// History is recorded per cycle, aligned to the combinational timeline when the output register is built in.
module tb_aes_skew_perm;
`ifdef AES_SKEW_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam logic [127:0] DIN_W  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] ENC_W  = 128'h00050A0F_04090E03_080D0207_0C01060B;
    localparam logic [127:0] DEC_W  = 128'h000D0A07_04010E0B_0805020F_0C090603;
    localparam logic [127:0] ROW0_W = 128'h00000000_04000000_08000000_0C000000;

    logic         CLK = 1'b0;
    logic         RSTN, CE, DIN_VALID, DEC;
    logic [127:0] DIN, DOUT;
    logic         DOUT_VALID;
    logic [255:0] din8, dout8;
    logic         dout8_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [127:0] h_dout [0:1023];
    logic         h_vld  [0:1023];

    always #5 CLK = ~CLK;

    aes_skew_perm #(.NCOL(4), .DW(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .DIN_VALID(DIN_VALID), .DEC(DEC),
        .DIN(DIN), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID)
    );

    aes_skew_perm #(.NCOL(8), .DW(8)) dut8 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .DIN_VALID(DIN_VALID), .DEC(DEC),
        .DIN(din8), .DOUT(dout8), .DOUT_VALID(dout8_valid)
    );

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (cyc >= LAT && cyc < 1024 + LAT) begin
            h_dout[cyc-LAT] <= DOUT;
            h_vld[cyc-LAT]  <= DOUT_VALID;
        end
    end

    function automatic logic [127:0] rep(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0; CE = 1'b1; DIN_VALID = 1'b0; DEC = 1'b0;
        next();
        next();
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        int t0;
        do_reset();
        DIN = DIN_W; DIN_VALID = 1'b1; DEC = 1'b0;
        t0 = cyc;
        next();
        next();
        checks++;
        if (h_dout[t0] !== ROW0_W)
            $display("FAIL reset_dout: got %h want %h", h_dout[t0], ROW0_W);
        if (h_dout[t0] !== ROW0_W) errors++;
        checks++;
        if (h_vld[t0] !== 1'b0) begin
            $display("FAIL reset_vld: got %b want 0", h_vld[t0]);
            errors++;
        end
    endtask

    task automatic test_encrypt();
        int t0;
        do_reset();
        DIN = DIN_W; DIN_VALID = 1'b1; DEC = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) next();
        next();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (h_vld[t0+i] !== (i == 3)) begin
                $display("FAIL enc_vld[%0d]: got %b want %b", i, h_vld[t0+i], (i == 3));
                errors++;
            end
        end
        for (int i = 3; i < 8; i += 4) begin
            checks++;
            if (h_dout[t0+i] !== ENC_W) begin
                $display("FAIL enc_dout[%0d]: got %h want %h", i, h_dout[t0+i], ENC_W);
                errors++;
            end
        end
        checks++;
        if (dout8[255 -: 32] !== 32'h00091A23) begin
            $display("FAIL n8_enc_col0: got %h want 00091a23", dout8[255 -: 32]);
            errors++;
        end
        checks++;
        if (dout8[31:0] !== 32'h3801121B) begin
            $display("FAIL n8_enc_col7: got %h want 3801121b", dout8[31:0]);
            errors++;
        end
        checks++;
        if (dout8_valid !== 1'b1) begin
            $display("FAIL n8_enc_vld: got %b want 1", dout8_valid);
            errors++;
        end
    endtask

    task automatic test_decrypt();
        int  t0;
        logic exp;
        do_reset();
        DIN = DIN_W; DIN_VALID = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            DEC = (i >= 10);
            next();
        end
        next();
        for (int i = 9; i < 14; i++) begin
            exp = (i == 9) || (i == 13);
            checks++;
            if (h_vld[t0+i] !== exp) begin
                $display("FAIL dec_vld[%0d]: got %b want %b", i, h_vld[t0+i], exp);
                errors++;
            end
        end
        for (int i = 13; i < 16; i += 2) begin
            checks++;
            if (h_dout[t0+i] !== DEC_W) begin
                $display("FAIL dec_dout[%0d]: got %h want %h", i, h_dout[t0+i], DEC_W);
                errors++;
            end
        end
        checks++;
        if (dout8[255 -: 32] !== 32'h00392A23) begin
            $display("FAIL n8_dec_col0: got %h want 00392a23", dout8[255 -: 32]);
            errors++;
        end
    endtask

    task automatic test_skew();
        int t0;
        do_reset();
        DIN_VALID = 1'b1; DEC = 1'b0;
        t0 = cyc;
        for (int t = 1; t <= 8; t++) begin
            DIN = rep(8'(t));
            next();
        end
        next();
        checks++;
        if (h_dout[t0+5] !== {4{32'h06050403}}) begin
            $display("FAIL skew_dout: got %h want %h", h_dout[t0+5], {4{32'h06050403}});
            errors++;
        end
        checks++;
        if (h_vld[t0+2] !== 1'b0) begin
            $display("FAIL skew_vld2: got %b want 0", h_vld[t0+2]);
            errors++;
        end
        checks++;
        if (h_vld[t0+3] !== 1'b1) begin
            $display("FAIL skew_vld3: got %b want 1", h_vld[t0+3]);
            errors++;
        end
    endtask

    task automatic test_gap();
        int t0;
        do_reset();
        DIN = DIN_W; DEC = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            DIN_VALID = (i != 5);
            next();
        end
        next();
        for (int i = 4; i < 10; i++) begin
            checks++;
            if (h_vld[t0+i] !== (i == 4 || i == 9)) begin
                $display("FAIL gap_vld[%0d]: got %b want %b", i, h_vld[t0+i], (i == 4 || i == 9));
                errors++;
            end
        end
        checks++;
        if (h_dout[t0+9] !== ENC_W) begin
            $display("FAIL gap_dout: got %h want %h", h_dout[t0+9], ENC_W);
            errors++;
        end
    endtask

    task automatic test_ce_hold();
        int t0;
        int k;
        do_reset();
        DIN_VALID = 1'b1; DEC = 1'b0;
        k  = 1;
        t0 = cyc;
        for (int i = 0; i < 9; i++) begin
            CE  = !(i == 5 || i == 6);
            DIN = rep(8'(k));
            next();
            if (CE) k++;
        end
        CE = 1'b1;
        next();
        checks++;
        if (h_vld[t0+4] !== 1'b1) begin
            $display("FAIL ce_vld_pre: got %b want 1", h_vld[t0+4]);
            errors++;
        end
`ifndef AES_SKEW_REG_OUT_EN
        for (int i = 5; i < 7; i++) begin
            checks++;
            if (h_vld[t0+i] !== 1'b0) begin
                $display("FAIL ce_vld_hold[%0d]: got %b want 0", i, h_vld[t0+i]);
                errors++;
            end
        end
`endif
        checks++;
        if (h_vld[t0+7] !== 1'b1) begin
            $display("FAIL ce_vld_resume: got %b want 1", h_vld[t0+7]);
            errors++;
        end
        checks++;
        if (h_dout[t0+7] !== {4{32'h06050403}}) begin
            $display("FAIL ce_dout7: got %h want %h", h_dout[t0+7], {4{32'h06050403}});
            errors++;
        end
        checks++;
        if (h_dout[t0+8] !== {4{32'h07060504}}) begin
            $display("FAIL ce_dout8: got %h want %h", h_dout[t0+8], {4{32'h07060504}});
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        do_reset();
        DIN = DIN_W; DIN_VALID = 1'b1; DEC = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            RSTN = (i != 6);
            next();
        end
        RSTN = 1'b1;
        next();
        for (int i = 7; i < 11; i++) begin
            checks++;
            if (h_vld[t0+i] !== (i == 10)) begin
                $display("FAIL rmid_vld[%0d]: got %b want %b", i, h_vld[t0+i], (i == 10));
                errors++;
            end
        end
        checks++;
        if (h_dout[t0+7] !== ROW0_W) begin
            $display("FAIL rmid_dout7: got %h want %h", h_dout[t0+7], ROW0_W);
            errors++;
        end
        checks++;
        if (h_dout[t0+10] !== ENC_W) begin
            $display("FAIL rmid_dout10: got %h want %h", h_dout[t0+10], ENC_W);
            errors++;
        end
    endtask

    initial begin
        RSTN = 1'b0; CE = 1'b1; DIN_VALID = 1'b0; DEC = 1'b0; DIN = '0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                din8[(8 - c) * 32 - r * 8 - 1 -: 8] = 8'(8 * c + r);
        next();
        test_reset();
        test_encrypt();
        test_decrypt();
        test_skew();
        test_gap();
        test_ce_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
